// File: rtl/shift_sequencer_pkg.sv
// Shared constants, op encodings and FSM state type for the multi-cycle shifter.
package shift_seq_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Launch/result bundle between the control unit (master) and the shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int unsigned WIDTH   = shift_seq_pkg::DEF_WIDTH,
  parameter int unsigned SHAMT_W = shift_seq_pkg::DEF_SHAMT_W
);

  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, operand, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand, shamt,
    output busy, done, result
  );

endinterface

// File: rtl/shift_sequencer_step.sv
// Single combinational shift stage: moves the value by 1 or 2 bits in the direction/fill chosen by op.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic             two,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in;
    unique case (op)
      OP_SLL: out = two ? {in[WIDTH-3:0], 2'b00} : {in[WIDTH-2:0], 1'b0};
      OP_SRL: out = two ? {2'b00, in[WIDTH-1:2]} : {1'b0, in[WIDTH-1:1]};
      OP_SRA: out = two ? {{2{in[WIDTH-1]}}, in[WIDTH-1:2]} : {in[WIDTH-1], in[WIDTH-1:1]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller: 2 bits per SHIFT cycle, final 1-bit step for odd amounts.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_t             state, state_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   step_out;
  logic [SHAMT_W-1:0] count, count_d;
  logic [1:0]         op_q, op_d;
  logic               two;

  assign two = (count >= SHAMT_W'(2));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .in  (acc),
    .op  (op_q),
    .two (two),
    .out (step_out)
  );

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    count_d  = count;
    op_d     = op_q;
    result_d = result_q;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_d   = bus.operand;
          count_d = bus.shamt;
          op_d    = bus.op;
          // Zero-amount and reserved ops skip SHIFT; result is the operand itself.
          if (bus.shamt == '0 || bus.op == OP_RSV) begin
            state_d  = DONE;
            result_d = bus.operand;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d   = step_out;
        count_d = two ? count - SHAMT_W'(2) : '0;
        if (count_d == '0) begin
          state_d  = DONE;
          result_d = step_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      count    <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer: latency, busy count, result and pulse shape.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a request now, lets one rising edge sample it, then scrambles the inputs.
  task automatic launch(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.operand = v;
    bus.shamt   = s;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.operand = 32'hDEAD_BEEF;
    bus.shamt   = 5'h1F;
    bus.op      = 2'b01;
  endtask

  // Counts edges after the start edge until done is seen; lat = -1 if the bound expires.
  task automatic wait_done(output int lat, output int busy_n, output int both_n);
    lat = 0;
    busy_n = 0;
    both_n = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy && bus.done) both_n++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL idle_hold: got busy=%b done=%b result=%h expected 0 0 00000000", bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_sll;
    int lat, bn, both;
    @(negedge clk);
    launch(2'b00, 32'hFFFF_FFFF, 5'd2);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 1 || bn !== 1) begin errors++; $display("FAIL sll2_latency: got lat=%0d busy=%0d expected 1 1", lat, bn); end
    checks++;
    if (bus.result !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sll2_result: got %h expected fffffffc", bus.result); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL sll2_pulse: got done=%b expected 0", bus.done); end
    @(negedge clk);
    launch(2'b00, 32'h0000_0001, 5'd31);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 16 || bn !== 16) begin errors++; $display("FAIL sll31_latency: got lat=%0d busy=%0d expected 16 16", lat, bn); end
    checks++;
    if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result: got %h expected 80000000", bus.result); end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL sll31_exclusive: got %0d overlaps expected 0", both); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_shift;
    int dones;
    @(negedge clk);
    launch(2'b00, 32'h0000_0001, 5'd20);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", bus.busy); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL midrst_state: got busy=%b done=%b result=%h expected 0 0 00000000", bus.busy, bus.done, bus.result);
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", dones); end
  endtask

  task automatic test_srl_sra;
    int lat, bn, both;
    @(negedge clk);
    launch(2'b01, 32'hCD6A_A5AD, 5'd5);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 3 || bn !== 3) begin errors++; $display("FAIL srl5_latency: got lat=%0d busy=%0d expected 3 3", lat, bn); end
    checks++;
    if (bus.result !== 32'h066B_552D) begin errors++; $display("FAIL srl5_result: got %h expected 066b552d", bus.result); end
    @(posedge clk);
    @(negedge clk);
    launch(2'b10, 32'hCD6A_A5AD, 5'd5);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 3 || bn !== 3) begin errors++; $display("FAIL sra5_latency: got lat=%0d busy=%0d expected 3 3", lat, bn); end
    checks++;
    if (bus.result !== 32'hFE6B_552D) begin errors++; $display("FAIL sra5_result: got %h expected fe6b552d", bus.result); end
    @(posedge clk);
  endtask

  task automatic test_zero_and_reserved;
    int lat, bn, both;
    @(negedge clk);
    launch(2'b10, 32'h8000_0000, 5'd0);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 0 || bn !== 0) begin errors++; $display("FAIL sra0_latency: got lat=%0d busy=%0d expected 0 0", lat, bn); end
    checks++;
    if (bus.result !== 32'h8000_0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sra0_result: got %h busy=%b expected 80000000 0", bus.result, bus.busy);
    end
    @(posedge clk);
    @(negedge clk);
    launch(2'b11, 32'h1234_5678, 5'd9);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 0 || bn !== 0) begin errors++; $display("FAIL rsv_latency: got lat=%0d busy=%0d expected 0 0", lat, bn); end
    checks++;
    if (bus.result !== 32'h1234_5678) begin errors++; $display("FAIL rsv_result: got %h expected 12345678", bus.result); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bn, both;
    @(negedge clk);
    launch(2'b01, 32'h0000_00F0, 5'd4);
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 2 || bus.result !== 32'h0000_000F) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d result=%h expected 2 0000000f", lat, bus.result);
    end
    launch(2'b00, 32'h0000_0003, 5'd4);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulse: got done=%b busy=%b expected 0 1", bus.done, bus.busy);
    end
    checks++;
    if (bus.result !== 32'h0000_000F) begin errors++; $display("FAIL b2b_hold: got %h expected 0000000f", bus.result); end
    wait_done(lat, bn, both);
    checks++;
    if (lat !== 2 || bn !== 2) begin errors++; $display("FAIL b2b_latency: got lat=%0d busy=%0d expected 2 2", lat, bn); end
    checks++;
    if (bus.result !== 32'h0000_0030) begin errors++; $display("FAIL b2b_result: got %h expected 00000030", bus.result); end
    @(posedge clk);
  endtask

  task automatic test_start_during_shift;
    int lat, bn, both, dones;
    @(negedge clk);
    launch(2'b00, 32'h0000_0001, 5'd10);
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    bus.operand = 32'hFFFF_FFFF;
    bus.shamt   = 5'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL busy_start_latency: got %0d expected 3", lat); end
    checks++;
    if (bus.result !== 32'h0000_0400) begin errors++; $display("FAIL busy_start_result: got %h expected 00000400", bus.result); end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL busy_start_extra_done: got %0d expected 0", dones); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.operand = 32'h0;
    bus.shamt   = 5'd0;
    test_reset;
    test_sll;
    test_reset_mid_shift;
    test_srl_sra;
    test_zero_and_reserved;
    test_back_to_back;
    test_start_during_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
